// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: funct3 access codes, writeback select encodings,
// MEM-stage FSM states and store lane helpers.
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } mem_state_e;

    // funct3[1:0] carries the access size; undefined codes fall through to word.
    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   return 4'b0001 << a;
            2'b01:   return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// Load data alignment: picks the addressed byte/half of the bus word and
// sign- or zero-extends it according to funct3.
module load_align
    import riscv_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (funct3_i)
            F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   data_o = {24'h0, byte_sel};
            F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   data_o = {16'h0, half_sel};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// RV32I MEM stage: drives the data bus for loads/stores, stalls the pipe while
// an access is in flight. Optional misalignment trap: define MISALIGN_TRAP_EN.
module mem_access_stage
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 8
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [2:0]  funct3_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] store_data_in,
    input  logic        reg_write_in,
    input  logic        mem_to_reg_in,
    input  logic [1:0]  wb_sel_in,
    input  logic [4:0]  rd_in,
    input  logic [31:0] pc_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic        bus_err,
    output logic        reg_write_out,
    output logic        mem_to_reg_out,
    output logic [1:0]  wb_sel_out,
    output logic [4:0]  rd_out,
    output logic [31:0] pc_out,
    output logic [31:0] alu_result_out,
    output logic [31:0] mem_data_out,
    output logic [1:0]  state_dbg
`ifdef MISALIGN_TRAP_EN
    ,
    output logic        misalign_trap
`endif
);

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);

    mem_state_e        state_q, state_d;
    logic              dmem_req_q, dmem_we_q;
    logic [31:0]       dmem_addr_q, dmem_wdata_q, rdata_q;
    logic [3:0]        dmem_be_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              mem_op, is_load, misaligned, timeout_hit;
    logic [31:0]       load_data;

    assign mem_op      = mem_read_in | mem_write_in;
    assign is_load     = mem_read_in & ~mem_write_in;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);

`ifdef MISALIGN_TRAP_EN
    logic misalign_q;
    always_comb begin
        case (funct3_in[1:0])
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = addr_in[0];
            default: misaligned = (addr_in[1:0] != 2'b00);
        endcase
    end
`else
    assign misaligned = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (mem_op) state_d = misaligned ? ST_ERR : ST_REQ;
            ST_REQ: begin
                if (dmem_ready)       state_d = ST_DONE;
                else if (timeout_hit) state_d = ST_ERR;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake: dmem_req and every bus field are registered and held stable
    // from the issue edge until the first cycle dmem_ready is high; dmem_rdata
    // is sampled on that same cycle. An access completes on req && ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= 32'h0;
            dmem_wdata_q <= 32'h0;
            dmem_be_q    <= 4'h0;
            rdata_q      <= 32'h0;
            cnt_q        <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (mem_op && !misaligned) begin
                        dmem_req_q   <= 1'b1;
                        dmem_we_q    <= mem_write_in;
                        dmem_addr_q  <= {addr_in[31:2], 2'b00};
                        dmem_be_q    <= store_be(funct3_in, addr_in[1:0]);
                        dmem_wdata_q <= store_wdata(funct3_in, store_data_in);
                    end
                end
                ST_REQ: begin
                    if (dmem_ready || timeout_hit) begin
                        dmem_req_q <= 1'b0;
                        dmem_we_q  <= 1'b0;
                        dmem_be_q  <= 4'h0;
                    end
                    if (dmem_ready) rdata_q <= dmem_rdata;
                    else            cnt_q   <= cnt_q + CNT_W'(1);
                end
                default: cnt_q <= '0;
            endcase
        end
    end

`ifdef MISALIGN_TRAP_EN
    // Remembers whether the coming ERR cycle is a trap rather than a bus timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    misalign_q <= 1'b0;
        else if (state_q == ST_IDLE) misalign_q <= mem_op & misaligned;
        else if (state_q == ST_ERR)  misalign_q <= 1'b0;
    end
`endif

    load_align u_load_align (
        .rdata_i   (rdata_q),
        .addr_lo_i (addr_in[1:0]),
        .funct3_i  (funct3_in),
        .data_o    (load_data)
    );

    always_comb begin
        stall         = 1'b0;
        reg_write_out = 1'b0;
        mem_data_out  = 32'h0;
        bus_err       = 1'b0;
`ifdef MISALIGN_TRAP_EN
        misalign_trap = 1'b0;
`endif
        if (!rst) begin
            case (state_q)
                ST_IDLE: begin
                    stall         = mem_op;
                    reg_write_out = reg_write_in & ~mem_op;
                end
                ST_REQ: stall = 1'b1;
                ST_DONE: begin
                    reg_write_out = reg_write_in;
                    mem_data_out  = is_load ? load_data : 32'h0;
                end
                default: begin
`ifdef MISALIGN_TRAP_EN
                    bus_err       = ~misalign_q;
                    misalign_trap = misalign_q;
`else
                    bus_err       = 1'b1;
`endif
                end
            endcase
        end
    end

    assign dmem_req       = dmem_req_q;
    assign dmem_we        = dmem_we_q;
    assign dmem_addr      = dmem_addr_q;
    assign dmem_wdata     = dmem_wdata_q;
    assign dmem_be        = dmem_be_q;
    assign mem_to_reg_out = mem_to_reg_in;
    assign wb_sel_out     = wb_sel_in;
    assign rd_out         = rd_in;
    assign pc_out         = pc_in;
    assign alu_result_out = addr_in;
    assign state_dbg      = state_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a responsive data-memory slave.
// Build with MISALIGN_TRAP_EN defined to exercise the misalignment trap.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read_in = 1'b0, mem_write_in = 1'b0;
    logic [2:0]  funct3_in = 3'b0;
    logic [31:0] addr_in = 32'h0, store_data_in = 32'h0, pc_in = 32'h0;
    logic        reg_write_in = 1'b0, mem_to_reg_in = 1'b0;
    logic [1:0]  wb_sel_in = 2'b0;
    logic [4:0]  rd_in = 5'h0;
    logic        dmem_ready = 1'b0;
    logic [31:0] dmem_rdata = 32'h0;
    logic        dmem_req, dmem_we, stall, bus_err, reg_write_out, mem_to_reg_out;
    logic [31:0] dmem_addr, dmem_wdata, pc_out, alu_result_out, mem_data_out;
    logic [3:0]  dmem_be;
    logic [1:0]  wb_sel_out, state_dbg;
    logic [4:0]  rd_out;
`ifdef MISALIGN_TRAP_EN
    logic        misalign_trap;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .funct3_in(funct3_in),
        .addr_in(addr_in), .store_data_in(store_data_in), .reg_write_in(reg_write_in),
        .mem_to_reg_in(mem_to_reg_in), .wb_sel_in(wb_sel_in), .rd_in(rd_in), .pc_in(pc_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_be(dmem_be), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .stall(stall), .bus_err(bus_err), .reg_write_out(reg_write_out),
        .mem_to_reg_out(mem_to_reg_out), .wb_sel_out(wb_sel_out), .rd_out(rd_out),
        .pc_out(pc_out), .alu_result_out(alu_result_out), .mem_data_out(mem_data_out),
        .state_dbg(state_dbg)
`ifdef MISALIGN_TRAP_EN
        , .misalign_trap(misalign_trap)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        mem_read_in = 1'b0; mem_write_in = 1'b0; reg_write_in = 1'b0;
        funct3_in = 3'b0; addr_in = 32'h0; store_data_in = 32'h0;
    endtask

    // Issues one memory op from IDLE; the slave raises ready after `waits`
    // request cycles. Returns observations taken at the retire cycle.
    task automatic mem_op(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd,
                          input logic [31:0] rdata, input int waits,
                          output int stalls, output logic [31:0] data, output logic rw,
                          output logic [31:0] q_addr, output logic [31:0] q_wdata,
                          output logic [3:0] q_be, output logic q_we,
                          output logic hold_ok, output logic done);
        int  reqcnt = 0;
        logic seen = 1'b0;
        mem_read_in = rd; mem_write_in = wr; funct3_in = f3; addr_in = a;
        store_data_in = sd; reg_write_in = rd & ~wr; dmem_ready = 1'b0;
        stalls = 0; data = 32'h0; rw = 1'b0; done = 1'b0; hold_ok = 1'b1;
        q_addr = 32'h0; q_wdata = 32'h0; q_be = 4'h0; q_we = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (dmem_req) begin
                if (!seen) begin
                    q_addr = dmem_addr; q_wdata = dmem_wdata; q_be = dmem_be; q_we = dmem_we;
                    seen = 1'b1;
                end else if (dmem_addr !== q_addr || dmem_be !== q_be || dmem_wdata !== q_wdata) begin
                    hold_ok = 1'b0;
                end
            end
            if (stall) stalls++;
            else begin
                data = mem_data_out; rw = reg_write_out; done = 1'b1;
            end
            next_cycle();
            if (dmem_req) begin
                dmem_ready = (reqcnt == waits);
                dmem_rdata = (reqcnt == waits) ? rdata : 32'hDEAD_BEEF;
                reqcnt++;
            end else begin
                dmem_ready = 1'b0;
            end
        end
        dmem_ready = 1'b0;
        clear_inputs();
    endtask

    initial begin
        int          stalls, req_cycles, err_seen;
        logic [31:0] data, q_addr, q_wdata;
        logic [3:0]  q_be;
        logic        rw, q_we, hold_ok, done;

        // Reset with a memory op present: combinational outputs must stay low.
        mem_write_in = 1'b1; reg_write_in = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_regwr", {31'b0, reg_write_out}, 32'd0);
        chk("rst_req", {31'b0, dmem_req}, 32'd0);
        chk("rst_be", {28'b0, dmem_be}, 32'h0);
        chk("rst_state", {30'b0, state_dbg}, 32'd0);
        chk("rst_memdata", mem_data_out, 32'h0);
        chk("rst_buserr", {31'b0, bus_err}, 32'd0);
        clear_inputs();
        next_cycle();
        rst = 1'b0;

        // Non-memory instruction passes straight through.
        reg_write_in = 1'b1; rd_in = 5'd5; pc_in = 32'h100; addr_in = 32'h1234;
        wb_sel_in = 2'b10; mem_to_reg_in = 1'b1;
        @(negedge clk);
        chk("add_stall", {31'b0, stall}, 32'd0);
        chk("add_regwr", {31'b0, reg_write_out}, 32'd1);
        chk("add_rd", {27'b0, rd_out}, 32'd5);
        chk("add_pc", pc_out, 32'h100);
        chk("add_alu", alu_result_out, 32'h1234);
        chk("add_wbsel", {30'b0, wb_sel_out}, 32'd2);
        chk("add_m2r", {31'b0, mem_to_reg_out}, 32'd1);
        next_cycle();
        @(negedge clk);
        chk("add_req", {31'b0, dmem_req}, 32'd0);
        next_cycle();
        clear_inputs();

        // SB to 0x1003, ready in first REQ cycle.
        mem_op(1'b0, 1'b1, 3'b000, 32'h1003, 32'h0000_00A5, 32'h0, 0,
               stalls, data, rw, q_addr, q_wdata, q_be, q_we, hold_ok, done);
        chk("sb_done", {31'b0, done}, 32'd1);
        chk("sb_stalls", stalls, 32'd2);
        chk("sb_addr", q_addr, 32'h1000);
        chk("sb_be", {28'b0, q_be}, 32'h8);
        chk("sb_wdata", q_wdata, 32'hA5A5_A5A5);
        chk("sb_we", {31'b0, q_we}, 32'd1);
        chk("sb_memdata", data, 32'h0);
        chk("sb_regwr", {31'b0, rw}, 32'd0);
        @(negedge clk);
        chk("sb_idle", {30'b0, state_dbg}, 32'd0);
        next_cycle();

        // SH to 0x1006: upper half lanes.
        mem_op(1'b0, 1'b1, 3'b001, 32'h1006, 32'h1234_BEEF, 32'h0, 1,
               stalls, data, rw, q_addr, q_wdata, q_be, q_we, hold_ok, done);
        chk("sh_stalls", stalls, 32'd3);
        chk("sh_be", {28'b0, q_be}, 32'hC);
        chk("sh_wdata", q_wdata, 32'hBEEF_BEEF);
        chk("sh_hold", {31'b0, hold_ok}, 32'd1);

        // LB at 0x2002 after three wait cycles.
        mem_op(1'b1, 1'b0, 3'b000, 32'h2002, 32'h0, 32'h12F0_3456, 3,
               stalls, data, rw, q_addr, q_wdata, q_be, q_we, hold_ok, done);
        chk("lb_done", {31'b0, done}, 32'd1);
        chk("lb_stalls", stalls, 32'd5);
        chk("lb_data", data, 32'hFFFF_FFF0);
        chk("lb_regwr", {31'b0, rw}, 32'd1);
        chk("lb_addr", q_addr, 32'h2000);
        chk("lb_we", {31'b0, q_we}, 32'd0);
        chk("lb_hold", {31'b0, hold_ok}, 32'd1);

        mem_op(1'b1, 1'b0, 3'b100, 32'h2002, 32'h0, 32'h12F0_3456, 0,
               stalls, data, rw, q_addr, q_wdata, q_be, q_we, hold_ok, done);
        chk("lbu_stalls", stalls, 32'd2);
        chk("lbu_data", data, 32'h0000_00F0);

        mem_op(1'b1, 1'b0, 3'b000, 32'h2001, 32'h0, 32'h12F0_3456, 0,
               stalls, data, rw, q_addr, q_wdata, q_be, q_we, hold_ok, done);
        chk("lb_pos_data", data, 32'h0000_0034);

        mem_op(1'b1, 1'b0, 3'b001, 32'h2002, 32'h0, 32'h8001_0000, 0,
               stalls, data, rw, q_addr, q_wdata, q_be, q_we, hold_ok, done);
        chk("lh_data", data, 32'hFFFF_8001);

        mem_op(1'b1, 1'b0, 3'b101, 32'h2002, 32'h0, 32'h8001_0000, 0,
               stalls, data, rw, q_addr, q_wdata, q_be, q_we, hold_ok, done);
        chk("lhu_data", data, 32'h0000_8001);

        mem_op(1'b1, 1'b0, 3'b010, 32'h3000, 32'h0, 32'hCAFE_F00D, 1,
               stalls, data, rw, q_addr, q_wdata, q_be, q_we, hold_ok, done);
        chk("lw_stalls", stalls, 32'd3);
        chk("lw_data", data, 32'hCAFE_F00D);

        mem_op(1'b1, 1'b0, 3'b110, 32'h3004, 32'h0, 32'h8765_4321, 0,
               stalls, data, rw, q_addr, q_wdata, q_be, q_we, hold_ok, done);
        chk("f3_110_data", data, 32'h8765_4321);

        // LW with the slave never answering: timeout after four REQ cycles.
        mem_read_in = 1'b1; funct3_in = 3'b010; addr_in = 32'h4000; reg_write_in = 1'b1;
        req_cycles = 0; err_seen = 0; stalls = 0;
        for (int c = 0; c < 20 && err_seen == 0; c++) begin
            @(negedge clk);
            if (dmem_req) req_cycles++;
            if (stall) stalls++;
            if (bus_err) begin
                err_seen = 1;
                chk("to_regwr", {31'b0, reg_write_out}, 32'd0);
                chk("to_stall", {31'b0, stall}, 32'd0);
                chk("to_memdata", mem_data_out, 32'h0);
                chk("to_req_low", {31'b0, dmem_req}, 32'd0);
            end
            next_cycle();
        end
        clear_inputs();
        chk("to_seen", err_seen, 32'd1);
        chk("to_req_cycles", req_cycles, 32'd4);
        chk("to_stalls", stalls, 32'd5);
        @(negedge clk);
        chk("to_pulse", {31'b0, bus_err}, 32'd0);
        chk("to_idle", {30'b0, state_dbg}, 32'd0);
        next_cycle();

        // Reset while a request is outstanding.
        mem_read_in = 1'b1; funct3_in = 3'b010; addr_in = 32'h5000; reg_write_in = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_req_up", {31'b0, dmem_req}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_req_async", {31'b0, dmem_req}, 32'd0);
        chk("mid_stall_async", {31'b0, stall}, 32'd0);
        clear_inputs();
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_idle", {30'b0, state_dbg}, 32'd0);
        chk("mid_stall", {31'b0, stall}, 32'd0);
        chk("mid_req", {31'b0, dmem_req}, 32'd0);
        next_cycle();

`ifdef MISALIGN_TRAP_EN
        // Misaligned LW: one stall cycle, trap pulse, no request.
        mem_read_in = 1'b1; funct3_in = 3'b010; addr_in = 32'h1002; reg_write_in = 1'b1;
        @(negedge clk);
        chk("mis_stall", {31'b0, stall}, 32'd1);
        chk("mis_req0", {31'b0, dmem_req}, 32'd0);
        next_cycle();
        @(negedge clk);
        chk("mis_trap", {31'b0, misalign_trap}, 32'd1);
        chk("mis_buserr", {31'b0, bus_err}, 32'd0);
        chk("mis_regwr", {31'b0, reg_write_out}, 32'd0);
        chk("mis_stall_err", {31'b0, stall}, 32'd0);
        chk("mis_req1", {31'b0, dmem_req}, 32'd0);
        next_cycle();
        clear_inputs();
        @(negedge clk);
        chk("mis_trap_clr", {31'b0, misalign_trap}, 32'd0);
        chk("mis_idle", {30'b0, state_dbg}, 32'd0);
        next_cycle();
`else
        // Misaligned LW without the trap: address is forced to word alignment.
        mem_op(1'b1, 1'b0, 3'b010, 32'h1002, 32'h0, 32'h1122_3344, 0,
               stalls, data, rw, q_addr, q_wdata, q_be, q_we, hold_ok, done);
        chk("mis_lw_addr", q_addr, 32'h1000);
        chk("mis_lw_data", data, 32'h1122_3344);
        chk("mis_lw_stalls", stalls, 32'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage of the RV32I 5-stage pipeline; sits between the EX/MEM register and the MEM/WB register.
- Executes LB/LH/LW/LBU/LHU/SB/SH/SW against a data-memory bus with a req/ready handshake.
- Stalls the pipeline while an access is outstanding.
- Presents aligned, extended load data and gated writeback control to the MEM/WB register.

Parameters:
- TIMEOUT_CYCLES, 16: REQ cycles without dmem_ready before a bus error. 0 disables the timeout.
- CNT_W, 8: width of the timeout counter. Must satisfy TIMEOUT_CYCLES < 2^CNT_W.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- mem_read_in  in  1  load instruction in stage
- mem_write_in  in  1  store instruction in stage
- funct3_in  in  3  access size/sign
- addr_in  in  32  effective address (ALU result)
- store_data_in  in  32  rs2 value
- reg_write_in  in  1  writeback enable from EX/MEM
- mem_to_reg_in  in  1  passthrough
- wb_sel_in  in  2  passthrough
- rd_in  in  5  passthrough
- pc_in  in  32  passthrough
- dmem_req  out  1  bus request (registered)
- dmem_we  out  1  write strobe
- dmem_addr  out  32  word address, {addr[31:2],2'b00}
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_ready  in  1  slave completion; rdata valid on the same cycle
- dmem_rdata  in  32  read word
- stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
- bus_err  out  1  one-cycle pulse on timeout
- reg_write_out  out  1  gated writeback enable to MEM/WB
- mem_to_reg_out, wb_sel_out, rd_out, pc_out, alu_result_out  out  1/2/5/32/32  passthroughs
- mem_data_out  out  32  extended load data

Behaviour:
- Reset: asynchronous. State=IDLE; dmem_req=0, dmem_we=0, dmem_be=0, dmem_addr=0, dmem_wdata=0. Counter=0. Captured read data=0. bus_err=0.
- Combinational outputs under reset: stall=0, reg_write_out=0, mem_data_out=0.
- Non-memory instruction (mem_read_in=0 and mem_write_in=0) in IDLE:
  - All passthroughs are combinational; reg_write_out=reg_write_in; stall=0.
  - Zero added latency.
- FSM states: IDLE, REQ, DONE, ERR.
  - IDLE, memory op present: stall=1, reg_write_out=0. On the clock edge, register dmem_req=1, dmem_we=mem_write_in, address, be and wdata, then go to REQ. If mem_read_in and mem_write_in are both set, the write takes priority.
  - REQ: stall=1, reg_write_out=0. Bus outputs are held stable until dmem_ready.
    - On dmem_ready: capture dmem_rdata, drop dmem_req/dmem_we/dmem_be, go to DONE.
    - Otherwise increment the counter. If TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES-1 without ready: drop the request and go to ERR.
  - DONE, one cycle: stall=0. reg_write_out=reg_write_in. mem_data_out=extended captured data for loads, 0 for stores. Counter clears. Next state is IDLE. The instruction retires here, and the next instruction is seen in IDLE on the following cycle.
  - ERR, one cycle: stall=0, bus_err=1, reg_write_out=0, mem_data_out=0, then go to IDLE.
- Latency: a memory op with ready in the first REQ cycle stalls 2 cycles and retires in cycle 3. Each wait cycle adds one.
- Store lanes:
  - SB (000): be=4'b0001<<addr[1:0], wdata={4{data[7:0]}}.
  - SH (001): be=addr[1]?4'b1100:4'b0011, wdata={2{data[15:0]}}.
  - SW (010): be=4'b1111.
- Load extract:
  - LB: select the byte by addr[1:0] and sign-extend.
  - LBU: select the byte by addr[1:0] and zero-extend.
  - LH: select the half by addr[1] and sign-extend.
  - LHU: select the half by addr[1] and zero-extend.
  - LW: full word.
  - Undefined funct3 (011/110/111) behaves as word.
- Reset mid-REQ: the request is abandoned and dmem_req drops asynchronously. The slave is required to tolerate an abandoned request.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - In IDLE, a misaligned op (half with addr[0]=1, or word with addr[1:0]≠0) issues no request and goes to ERR.
  - In that ERR cycle, misalign_trap (extra 1-bit out port) =1 and bus_err=0. It takes 1 stall cycle, then retires with reg_write_out=0.
- Undefined:
  - The port is absent and low address bits are ignored: halves use addr[1], words use a forced-aligned address. No trap.

Decomposition:
- Shared package riscv_pkg: funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU, wb_sel encodings, FSM state encoding.
- One natural combinational sub-module: load_align. Inputs are rdata, addr[1:0] and funct3; output is the 32-bit extended data.

Test Plan:
- ADD (no mem op) with reg_write_in=1: stall=0 and reg_write_out=1 in the same cycle; dmem_req never asserts.
- SB with addr=0x1003, data=0x000000A5, ready in 1st REQ: dmem_addr=0x1000, be=4'b1000, wdata=0xA5A5A5A5. stall high for 2 cycles, then DONE.
- LB at addr=0x2002 with rdata=0x12F0_3456, ready after 3 waits: 5 stall cycles, then mem_data_out=0xFFFFFFF0. LBU at the same address gives 0x000000F0.
- LH at addr=0x2002, rdata=0x8001_0000: mem_data_out=0xFFFF8001. LHU gives 0x00008001.
- LW with TIMEOUT_CYCLES=4 and ready never asserted: dmem_req high for 4 cycles, then bus_err pulses 1 cycle, reg_write_out=0, then IDLE.
- rst asserted mid-REQ: dmem_req drops without waiting for clk; after release, state is IDLE and stall=0. With MISALIGN_TRAP_EN defined, LW at 0x1002 gives misalign_trap=1 and no dmem_req.
